// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
//   Round-robin arbiter sharing one FIFO read port among NUM_REQ consumers.
//   A consumer is granted for a burst of up to BURST_LEN pops. The arbiter
//   drives the FIFO read enable and steers the returned data to the granted
//   consumer with a one-hot valid.
//
// Ports
//   i_clk         read-domain clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_req         per-consumer read request (level)
//   o_gnt         one-hot grant (registered)
//   i_fifo_empty  FIFO empty flag
//   o_fifo_rd_en  FIFO read enable (combinational)
//   i_fifo_rdata  FIFO read data, valid one cycle after an accepted rd_en
//   o_rdata       passthrough of i_fifo_rdata
//   o_rd_valid    one-hot qualifier for o_rdata (registered)
//   o_busy        high while a grant is active
//
// State table
//   IDLE  | no grant; pick next requester round-robin when FIFO not empty
//   GRANT | one consumer owns the read port until it drops req or bursts out
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req,
  output logic [NUM_REQ-1:0]    o_gnt,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [NUM_REQ-1:0]    o_rd_valid,
  output logic                  o_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] BURST_MAX  = CW'(BURST_LEN);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LAST_RST   = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        sel_idx;
  logic                 sel_found;
  logic                 rd_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  // Round-robin pick: first requester scanning upward from last+1.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_v;
    idx       = 0;
    idx_v     = '0;
    sel_found = 1'b0;
    sel_idx   = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_q) + i) % NUM_REQ;
      idx_v = idx[IW-1:0];
      if (!sel_found && i_req[idx_v]) begin
        sel_found = 1'b1;
        sel_idx   = idx_v;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found && !i_fifo_empty) begin
          state_d          = GRANT;
          gnt_d            = '0;
          gnt_d[sel_idx]   = 1'b1;
          last_d           = sel_idx;
          cnt_d            = '0;
        end
      end
      GRANT: begin
        // last_q holds the granted index for the whole burst.
        rd_en = i_req[last_q] && !i_fifo_empty && (cnt_q < BURST_MAX);
        if (rd_en) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (!i_req[last_q] || (rd_en && (cnt_q == BURST_LAST))) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Valid lags the pop by one cycle, so the final pop's valid lands in IDLE.
  assign rd_valid_d   = gnt_q & {NUM_REQ{rd_en}};

  assign o_gnt        = gnt_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_fifo_rd_en = rd_en;
  assign o_rdata      = i_fifo_rdata;
  assign o_busy       = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       fifo_empty;
  logic       rd_en;
  logic [7:0] fifo_rdata = 8'h00;
  logic [7:0] rdata;
  logic [3:0] rd_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // FIFO model: wr_total written by the stimulus, pops_total by the model.
  int wr_total   = 0;
  int pops_total = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_total == pops_total);

  always @(posedge clk) begin
    if (rd_en && !fifo_empty) begin
      fifo_rdata <= 8'hA0 + 8'(pops_total);
      pops_total <= pops_total + 1;
    end
  end

  fifo_rd_arbiter #(.NUM_REQ(4), .BURST_LEN(4), .DATA_WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .o_gnt        (gnt),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd_en (rd_en),
    .i_fifo_rdata (fifo_rdata),
    .o_rdata      (rdata),
    .o_rd_valid   (rd_valid),
    .o_busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] e_gnt, input logic e_rd_en,
                           input logic [3:0] e_valid, input logic e_busy);
    chk({tag, ".gnt"},      32'(gnt),      32'(e_gnt));
    chk({tag, ".rd_en"},    32'(rd_en),    32'(e_rd_en));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_valid));
    chk({tag, ".busy"},     32'(busy),     32'(e_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    logic [3:0] oh;
    logic [3:0] prev_oh;
    order = '{0, 1, 2, 3, 0};

    // Reset state
    tick; tick;
    chk_state("reset", 4'b0000, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    tick;

    // Empty FIFO in IDLE: no grant
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_state("empty_idle", 4'b0000, 1'b0, 4'b0000, 1'b0);
    end

    // One entry: one pop, grant held while empty, resume after write
    wr_total = 1;
    #1;
    chk("one_entry.pre_rd_en", 32'(rd_en), 32'h0);
    tick;
    chk_state("one_entry.g0", 4'b0001, 1'b1, 4'b0000, 1'b1);
    tick;
    chk_state("one_entry.g1", 4'b0001, 1'b0, 4'b0001, 1'b1);
    chk("one_entry.rdata", 32'(rdata), 32'hA0);
    tick;
    chk_state("hold.g2", 4'b0001, 1'b0, 4'b0000, 1'b1);
    tick;
    chk_state("hold.g3", 4'b0001, 1'b0, 4'b0000, 1'b1);
    wr_total = 10;
    #1;
    chk_state("resume.p1", 4'b0001, 1'b1, 4'b0000, 1'b1);
    tick;
    chk_state("resume.p2", 4'b0001, 1'b1, 4'b0001, 1'b1);
    tick;
    chk_state("resume.p3", 4'b0001, 1'b1, 4'b0001, 1'b1);
    tick;
    chk_state("resume.release", 4'b0000, 1'b0, 4'b0001, 1'b0);
    chk("resume.rdata", 32'(rdata), 32'hA3);
    req = 4'b0000;
    tick;
    chk_state("resume.idle", 4'b0000, 1'b0, 4'b0000, 1'b0);
    chk("resume.pops", 32'(pops_total), 32'd4);

    // Single requester burst on index 2
    wr_total = 200;
    req = 4'b0100;
    #1;
    chk_state("burst.req", 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick;
    for (int k = 0; k < 4; k++) begin
      chk_state("burst.beat", 4'b0100, 1'b1, (k == 0) ? 4'b0000 : 4'b0100, 1'b1);
      if (k > 0) chk("burst.rdata", 32'(rdata), 32'(8'hA3 + 8'(k)));
      tick;
    end
    chk_state("burst.idle", 4'b0000, 1'b0, 4'b0100, 1'b0);
    chk("burst.rdata_last", 32'(rdata), 32'hA7);
    tick;
    chk("burst.regrant", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick;
    chk_state("burst.drop", 4'b0000, 1'b0, 4'b0000, 1'b0);
    chk("burst.pops", 32'(pops_total), 32'd8);

    // Round-robin fairness from a fresh reset (last=3)
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req = 4'b1111;
    tick;
    prev_oh = 4'b0000;
    for (int gi = 0; gi < 5; gi++) begin
      oh = 4'b0001 << order[gi];
      for (int k = 0; k < 4; k++) begin
        chk_state("rr.beat", oh, 1'b1, (k == 0) ? 4'b0000 : oh, 1'b1);
        tick;
      end
      chk_state("rr.idle", 4'b0000, 1'b0, oh, 1'b0);
      prev_oh = oh;
      tick;
    end
    chk("rr.next", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick;
    chk_state("rr.drop", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Early drop of req[1] after 2 pops; req 0 and 2 arrive during GRANT
    req = 4'b0010;
    tick;
    chk_state("early.k0", 4'b0010, 1'b1, 4'b0000, 1'b1);
    tick;
    chk_state("early.k1", 4'b0010, 1'b1, 4'b0010, 1'b1);
    tick;
    req = 4'b0101;
    #1;
    chk_state("early.k2", 4'b0010, 1'b0, 4'b0010, 1'b1);
    tick;
    chk_state("early.release", 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick;
    chk("early.next", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick;
    chk_state("early.drop", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Last-pointer wrap
    req = 4'b1000;
    tick;
    chk("wrap.set3", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick;
    req = 4'b1001;
    tick;
    chk("wrap.last3", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick;
    req = 4'b1001;
    tick;
    chk("wrap.last0", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick;

    // Reset mid-burst after 3 pops
    req = 4'b0001;
    tick;
    chk("midrst.gnt", 32'(gnt), 32'h1);
    tick; tick; tick;
    chk_state("midrst.pre", 4'b0001, 1'b1, 4'b0001, 1'b1);
    rst = 1'b1;
    #1;
    chk_state("midrst.async", 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick;
    chk_state("midrst.held", 4'b0000, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    tick;
    chk_state("midrst.regrant", 4'b0001, 1'b1, 4'b0000, 1'b1);
    req = 4'b0000;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
